// File: rtl/alarm_clock_defs.sv
// Shared definitions for the alarm clock keypad front end.
// Holds the key code constants, the debounce FSM state encoding and small
// helpers that map a matrix position to a key code.
package alarm_clock_defs;

  localparam logic [3:0] KEY_NONE  = 4'd10;
  localparam logic [3:0] KEY_STAR  = 4'd11;
  localparam logic [3:0] KEY_HASH  = 4'd12;
  localparam logic [3:0] KEY_MULTI = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_HELD    = 2'd2,
    ST_RELEASE = 2'd3
  } kp_state_e;

  // Telephone layout: rows 0-2 carry 1-9, row 3 carries * 0 #.
  function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'b00_00: code = 4'd1;
      4'b00_01: code = 4'd2;
      4'b00_10: code = 4'd3;
      4'b01_00: code = 4'd4;
      4'b01_01: code = 4'd5;
      4'b01_10: code = 4'd6;
      4'b10_00: code = 4'd7;
      4'b10_01: code = 4'd8;
      4'b10_10: code = 4'd9;
      4'b11_00: code = KEY_STAR;
      4'b11_01: code = 4'd0;
      4'b11_10: code = KEY_HASH;
      default:  code = KEY_MULTI;
    endcase
    return code;
  endfunction

  // True for a single, acceptable key (digit, star or hash).
  function automatic logic is_code(input logic [3:0] k);
    return (k <= 4'd9) || (k == KEY_STAR) || (k == KEY_HASH);
  endfunction

endpackage

// File: rtl/keypad_debounce_fsm.sv
// Debounce state machine for the keypad scanner.
// Consumes one full-scan result per scan_done strobe and decides which key
// is considered held. Outputs are registered.
//   clock           : system clock
//   reset           : synchronous active-low reset
//   i_scan_done     : one-cycle strobe, i_scan_result is valid
//   i_scan_result   : NONE / digit / STAR / HASH / MULTI
//   o_key           : held digit 0-9, else KEY_NONE
//   o_time_button   : one-cycle pulse when '#' becomes held
//   o_alarm_button  : one-cycle pulse when '*' becomes held
module keypad_debounce_fsm
  import alarm_clock_defs::*;
#(
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       i_scan_done,
  input  logic [3:0] i_scan_result,
  output logic [3:0] o_key,
  output logic       o_time_button,
  output logic       o_alarm_button
);

  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_SCANS);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  kp_state_e        r_state;
  kp_state_e        w_state_nxt;
  logic [3:0]       r_cand;
  logic [3:0]       w_cand_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_enter_held;
  logic [3:0]       r_key;
  logic             r_time_button;
  logic             r_alarm_button;

  // Saturating increment of the scan counter.
  always_comb begin
    if (r_cnt == CNT_LAST) begin
      w_cnt_inc = r_cnt;
    end else begin
      w_cnt_inc = r_cnt + CNT_ONE;
    end
  end

  // Next-state logic; only advances on a completed scan.
  always_comb begin
    w_state_nxt  = r_state;
    w_cand_nxt   = r_cand;
    w_cnt_nxt    = r_cnt;
    w_enter_held = 1'b0;
    if (i_scan_done) begin
      case (r_state)
        ST_IDLE: begin
          if (is_code(i_scan_result)) begin
            w_cand_nxt = i_scan_result;
            w_cnt_nxt  = CNT_ONE;
            if (DEBOUNCE_SCANS == 1) begin
              w_state_nxt  = ST_HELD;
              w_enter_held = 1'b1;
            end else begin
              w_state_nxt = ST_CONFIRM;
            end
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_CONFIRM: begin
          if (i_scan_result == r_cand) begin
            w_cnt_nxt = w_cnt_inc;
            if (w_cnt_inc == CNT_LAST) begin
              w_state_nxt  = ST_HELD;
              w_enter_held = 1'b1;
            end else begin
              w_state_nxt = ST_CONFIRM;
            end
          end else begin
            w_state_nxt = ST_IDLE;
            w_cand_nxt  = KEY_NONE;
            w_cnt_nxt   = CNT_ZERO;
          end
        end
        ST_HELD: begin
          if (i_scan_result == r_cand) begin
            w_state_nxt = ST_HELD;
          end else if (DEBOUNCE_SCANS == 1) begin
            // A single mismatching scan already completes the release.
            w_state_nxt = ST_IDLE;
            w_cand_nxt  = KEY_NONE;
            w_cnt_nxt   = CNT_ZERO;
          end else begin
            w_state_nxt = ST_RELEASE;
            w_cnt_nxt   = CNT_ONE;
          end
        end
        ST_RELEASE: begin
          if (i_scan_result == r_cand) begin
            // Re-entry to HELD is silent: no button pulse.
            w_state_nxt = ST_HELD;
            w_cnt_nxt   = CNT_ZERO;
          end else begin
            w_cnt_nxt = w_cnt_inc;
            if (w_cnt_inc == CNT_LAST) begin
              w_state_nxt = ST_IDLE;
              w_cand_nxt  = KEY_NONE;
              w_cnt_nxt   = CNT_ZERO;
            end else begin
              w_state_nxt = ST_RELEASE;
            end
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cand_nxt  = KEY_NONE;
          w_cnt_nxt   = CNT_ZERO;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // State, candidate, counter and registered outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state        <= ST_IDLE;
      r_cand         <= KEY_NONE;
      r_cnt          <= CNT_ZERO;
      r_key          <= KEY_NONE;
      r_time_button  <= 1'b0;
      r_alarm_button <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_cand         <= w_cand_nxt;
      r_cnt          <= w_cnt_nxt;
      r_key          <= (((w_state_nxt == ST_HELD) || (w_state_nxt == ST_RELEASE)) &&
                         (w_cand_nxt <= 4'd9)) ? w_cand_nxt : KEY_NONE;
      r_time_button  <= w_enter_held && (w_cand_nxt == KEY_HASH);
      r_alarm_button <= w_enter_held && (w_cand_nxt == KEY_STAR);
    end
  end

  assign o_key          = r_key;
  assign o_time_button  = r_time_button;
  assign o_alarm_button = r_alarm_button;

endmodule

// File: rtl/keypad_scanner.sv
// 4x3 telephone keypad scanner with debounce.
// Drives one row low at a time, synchronises the column sense lines, folds
// each row's hits into a full-scan result and hands that result to the
// debounce FSM once per scan.
//   clock        : system clock
//   reset        : synchronous active-low reset
//   row_n[3:0]   : active-low row drive, one bit low at a time
//   col_n[2:0]   : active-low asynchronous column sense
//   key[3:0]     : debounced digit 0-9 while held, else 10
//   time_button  : one-cycle pulse on accepted '#'
//   alarm_button : one-cycle pulse on accepted '*'
module keypad_scanner
  import alarm_clock_defs::*;
#(
  parameter int SCAN_DIV       = 4,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic       clock,
  input  logic       reset,
  output logic [3:0] row_n,
  input  logic [2:0] col_n,
  output logic [3:0] key,
  output logic       time_button,
  output logic       alarm_button
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ZERO = DIV_W'(0);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_row_idx;
  logic [3:0]       r_row_n;
  logic [2:0]       r_col_meta;
  logic [2:0]       r_col_sync;
  logic [3:0]       r_acc;
  logic [3:0]       r_scan_result;
  logic             r_scan_done;
  logic             w_sample;
  logic             w_last_row;
  logic [2:0]       w_hits;
  logic [3:0]       w_row_code;
  logic [3:0]       w_merged;

  assign w_sample   = (r_div == DIV_LAST);
  assign w_last_row = (r_row_idx == 2'd3);

  // Row dwell divider and row rotation; the row advances on the sample cycle.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_div     <= DIV_ZERO;
      r_row_idx <= 2'd0;
      r_row_n   <= 4'b1110;
    end else if (w_sample) begin
      r_div     <= DIV_ZERO;
      r_row_idx <= r_row_idx + 2'd1;
      r_row_n   <= {r_row_n[2:0], r_row_n[3]};
    end else begin
      r_div     <= r_div + DIV_ONE;
      r_row_idx <= r_row_idx;
      r_row_n   <= r_row_n;
    end
  end

  // Two-flop synchroniser for the asynchronous column lines.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_col_meta <= 3'b111;
      r_col_sync <= 3'b111;
    end else begin
      r_col_meta <= col_n;
      r_col_sync <= r_col_meta;
    end
  end

  // Decode the current row: none, exactly one column, or several.
  always_comb begin
    w_hits = ~r_col_sync;
    case (w_hits)
      3'b000:  w_row_code = KEY_NONE;
      3'b001:  w_row_code = key_code(r_row_idx, 2'd0);
      3'b010:  w_row_code = key_code(r_row_idx, 2'd1);
      3'b100:  w_row_code = key_code(r_row_idx, 2'd2);
      default: w_row_code = KEY_MULTI;
    endcase
  end

  // Merge the row result into the scan so far; any second hit means MULTI.
  always_comb begin
    if (r_acc == KEY_NONE) begin
      w_merged = w_row_code;
    end else if (w_row_code == KEY_NONE) begin
      w_merged = r_acc;
    end else begin
      w_merged = KEY_MULTI;
    end
  end

  // Scan accumulator; the row-3 sample closes the scan and strobes scan_done.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_acc         <= KEY_NONE;
      r_scan_result <= KEY_NONE;
      r_scan_done   <= 1'b0;
    end else if (w_sample && w_last_row) begin
      r_acc         <= KEY_NONE;
      r_scan_result <= w_merged;
      r_scan_done   <= 1'b1;
    end else if (w_sample) begin
      r_acc         <= w_merged;
      r_scan_result <= r_scan_result;
      r_scan_done   <= 1'b0;
    end else begin
      r_acc         <= r_acc;
      r_scan_result <= r_scan_result;
      r_scan_done   <= 1'b0;
    end
  end

  keypad_debounce_fsm #(
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
  ) u_debounce (
    .clock          (clock),
    .reset          (reset),
    .i_scan_done    (r_scan_done),
    .i_scan_result  (r_scan_result),
    .o_key          (key),
    .o_time_button  (time_button),
    .o_alarm_button (alarm_button)
  );

  assign row_n = r_row_n;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner (SCAN_DIV=4, DEBOUNCE_SCANS=3).
// Stimulus holds a set of pressed keys constant over each 16-cycle scan and
// pushes the expected key/pulse outcome of that scan; a negedge monitor pops
// one entry per scan and otherwise checks that outputs stay steady.
module tb_keypad_scanner;

  localparam int D       = 3;
  localparam int K_NONE  = 10;
  localparam int K_STAR  = 11;
  localparam int K_HASH  = 12;
  localparam int K_MULTI = 15;

  typedef struct {
    int key;
    int tb;
    int ab;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  row_n;
  logic [2:0]  col_n;
  logic [3:0]  key;
  logic        time_button;
  logic        alarm_button;
  logic [11:0] pressed = 12'd0;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int unsigned n_edge   = 0;
  int          cur_key  = K_NONE;
  bit          mon_en   = 1'b0;

  // Reference model state: candidate key, accepted flag, run length.
  int m_cand = K_NONE;
  bit m_held = 1'b0;
  int m_run  = 0;

  always #5 clock = ~clock;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(D)) dut (
    .clock        (clock),
    .reset        (reset),
    .row_n        (row_n),
    .col_n        (col_n),
    .key          (key),
    .time_button  (time_button),
    .alarm_button (alarm_button)
  );

  // Key matrix: a pressed key shorts its row to its column.
  always_comb begin
    col_n = 3'b111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (pressed[r*3+c] && !row_n[r]) col_n[c] = 1'b0;
      end
    end
  end

  always @(posedge clock) begin
    if (!reset) n_edge <= 0;
    else        n_edge <= n_edge + 1;
  end

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
  endtask

  function automatic int scan_result(input logic [11:0] p);
    int map [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, K_STAR, 0, K_HASH};
    int cnt = 0;
    int code = K_NONE;
    for (int i = 0; i < 12; i++) begin
      if (p[i]) begin
        cnt++;
        code = map[i];
      end
    end
    if (cnt == 0) return K_NONE;
    if (cnt > 1) return K_MULTI;
    return code;
  endfunction

  function automatic bit single_key(input int k);
    return (k <= 9) || (k == K_STAR) || (k == K_HASH);
  endfunction

  // Apply a pressed set for one full scan and record the expected outcome.
  task automatic do_scan(input logic [11:0] p);
    int   res;
    bit   pulse;
    exp_t e;
    pressed = p;
    res     = scan_result(p);
    pulse   = 1'b0;
    if (!m_held) begin
      if (m_cand == K_NONE) begin
        if (single_key(res)) begin
          m_cand = res;
          m_run  = 1;
        end
      end else if (res == m_cand) begin
        m_run++;
      end else begin
        m_cand = K_NONE;
        m_run  = 0;
      end
      if (m_cand != K_NONE && m_run >= D) begin
        m_held = 1'b1;
        pulse  = 1'b1;
        m_run  = 0;
      end
    end else begin
      if (res == m_cand) begin
        m_run = 0;
      end else begin
        m_run++;
        if (m_run >= D) begin
          m_held = 1'b0;
          m_cand = K_NONE;
          m_run  = 0;
        end
      end
    end
    e.key = (m_held && m_cand <= 9) ? m_cand : K_NONE;
    e.tb  = (pulse && m_cand == K_HASH) ? 1 : 0;
    e.ab  = (pulse && m_cand == K_STAR) ? 1 : 0;
    exp_q.push_back(e);
    repeat (16) @(posedge clock);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    exp_q.delete();
    m_cand  = K_NONE;
    m_held  = 1'b0;
    m_run   = 0;
    cur_key = K_NONE;
  endtask

  // Monitor: row rotation every cycle, scoreboard pop once per scan.
  always @(negedge clock) begin
    if (mon_en) begin
      logic [3:0] exp_row;
      exp_t e;
      exp_row = 4'hF & ~(4'b0001 << ((n_edge / 4) % 4));
      check("row_n", int'(row_n), int'(exp_row));
      if (n_edge >= 17 && (n_edge % 16) == 1) begin
        if (exp_q.size() == 0) begin
          check("scoreboard_empty", 1, 0);
        end else begin
          e = exp_q.pop_front();
          cur_key = e.key;
          check("key_scan", int'(key), e.key);
          check("time_button_scan", int'(time_button), e.tb);
          check("alarm_button_scan", int'(alarm_button), e.ab);
        end
      end else begin
        check("key_steady", int'(key), cur_key);
        check("time_button_idle", int'(time_button), 0);
        check("alarm_button_idle", int'(alarm_button), 0);
      end
    end
  end

  initial begin
    logic [11:0] p;
    logic [11:0] one;
    one = 12'd1;
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset  = 1'b1;
    mon_en = 1'b1;

    // Idle scanning.
    for (int i = 0; i < 7; i++) do_scan(12'd0);
    // Digit 6 held, then released.
    for (int i = 0; i < 8; i++) do_scan(one << 5);
    for (int i = 0; i < 4; i++) do_scan(12'd0);
    // '#' then '*'.
    for (int i = 0; i < 5; i++) do_scan(one << 11);
    for (int i = 0; i < 4; i++) do_scan(12'd0);
    for (int i = 0; i < 5; i++) do_scan(one << 9);
    for (int i = 0; i < 4; i++) do_scan(12'd0);
    // Bouncing 5, then steady.
    for (int i = 0; i < 6; i++) do_scan((i % 2 == 0) ? (one << 4) : 12'd0);
    for (int i = 0; i < 4; i++) do_scan(one << 4);
    for (int i = 0; i < 4; i++) do_scan(12'd0);
    // 2 and 8 together; then 4 with 7 added briefly.
    for (int i = 0; i < 4; i++) do_scan((one << 1) | (one << 7));
    for (int i = 0; i < 3; i++) do_scan(12'd0);
    for (int i = 0; i < 4; i++) do_scan(one << 3);
    for (int i = 0; i < 2; i++) do_scan((one << 3) | (one << 6));
    for (int i = 0; i < 2; i++) do_scan(one << 3);
    for (int i = 0; i < 4; i++) do_scan(12'd0);
    // Reset while 9 is held; 9 must come back after three scans.
    for (int i = 0; i < 4; i++) do_scan(one << 8);
    pulse_reset();
    for (int i = 0; i < 4; i++) do_scan(one << 8);
    for (int i = 0; i < 4; i++) do_scan(12'd0);

    // Randomised key activity with long holds.
    p = 12'd0;
    for (int s = 0; s < 90; s++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 5) begin
        p = p;
      end else if (r < 7) begin
        p = 12'd0;
      end else if (r < 9) begin
        p = one << $urandom_range(0, 11);
      end else begin
        p = (one << $urandom_range(0, 11)) | (one << $urandom_range(0, 11));
      end
      do_scan(p);
    end
    for (int i = 0; i < 4; i++) do_scan(12'd0);
    repeat (3) @(posedge clock);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
